// File: rtl/rf_wb_port_arbiter.sv
// Purpose: shares NUM_WP regfile write ports among NUM_REQ writeback sources (escalated-first, then round-robin; drops same-cycle address duplicates; x0 writes are accepted but not performed).
// Latency: req_ready_o is combinational; a grant in cycle N drives we_o/waddr_o/wdata_o in cycle N+1.
// Backpressure: losers see ready=0 and retry with held addr/data; arb_en_i=0 stalls everyone. Optional macro RF_WB_FWD_EN adds an output-stage forwarding lookup.
module rf_wb_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_WP       = 2,
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arb_en_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_WP-1:0]              we_o,
    output logic [NUM_WP*ADDR_WIDTH-1:0]   waddr_o,
    output logic [NUM_WP*DATA_WIDTH-1:0]   wdata_o,
    output logic [NUM_REQ-1:0]             starved_o
`ifdef RF_WB_FWD_EN
    ,
    input  logic [ADDR_WIDTH-1:0]          fwd_raddr_i,
    output logic                           fwd_hit_o,
    output logic [DATA_WIDTH-1:0]          fwd_data_o
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]               rr_ptr;
    logic [PTR_W-1:0]               rr_ptr_nxt;
    logic [CNT_W-1:0]               starve_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]             starved;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_WP-1:0]              port_we;
    logic [NUM_WP*ADDR_WIDTH-1:0]   port_addr;
    logic [NUM_WP*DATA_WIDTH-1:0]   port_data;

    // A requester is escalated once its stall counter has saturated.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            starved[k] = (starve_cnt[k] == LIMIT);
        end
    end

    // Two passes over the requesters: escalated ones in index order, then the rest
    // circularly from rr_ptr. Each non-x0 winner takes the lowest free port.
    always_comb begin : arb_comb
        int                    idx;
        logic [PTR_W-1:0]      k;
        logic [ADDR_WIDTH-1:0] cur_addr;
        logic                  esc_pass;
        logic                  conflict;
        logic                  placed;
        grant      = '0;
        port_we    = '0;
        port_addr  = '0;
        port_data  = '0;
        rr_ptr_nxt = rr_ptr;
        idx        = 0;
        k          = '0;
        cur_addr   = '0;
        esc_pass   = 1'b0;
        conflict   = 1'b0;
        placed     = 1'b0;
        if (arb_en_i) begin
            for (int j = 0; j < 2 * NUM_REQ; j++) begin
                esc_pass = (j < NUM_REQ);
                idx = esc_pass ? j : int'(rr_ptr) + j - NUM_REQ;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                k        = idx[PTR_W-1:0];
                cur_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                if (req_valid_i[k] && (starved[k] == esc_pass)) begin
                    if (cur_addr == '0) begin
                        // x0 writes are architecturally discarded: accept without a port.
                        grant[k] = 1'b1;
                    end else begin
                        conflict = 1'b0;
                        for (int p = 0; p < NUM_WP; p++) begin
                            if (port_we[p] && (port_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == cur_addr)) begin
                                conflict = 1'b1;
                            end
                        end
                        placed = 1'b0;
                        if (!conflict) begin
                            for (int p = 0; p < NUM_WP; p++) begin
                                if (!placed && !port_we[p]) begin
                                    port_we[p]                            = 1'b1;
                                    port_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = cur_addr;
                                    port_data[p*DATA_WIDTH +: DATA_WIDTH] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                                    placed                                = 1'b1;
                                end
                            end
                        end
                        grant[k] = placed;
                    end
                    if (grant[k] && !esc_pass) begin
                        rr_ptr_nxt = (k == LAST_IDX) ? '0 : k + 1'b1;
                    end
                end
            end
        end
    end

    // Ready is suppressed during reset so no source believes a transfer happened.
    assign req_ready_o = rst ? '0 : grant;
    assign starved_o   = starved;

    // Round-robin pointer and per-requester stall counters; frozen while arbitration is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                starve_cnt[k] <= '0;
            end
        end else if (arb_en_i) begin
            rr_ptr <= rr_ptr_nxt;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant[k]) begin
                    starve_cnt[k] <= '0;
                end else if (req_valid_i[k] && (starve_cnt[k] != LIMIT)) begin
                    starve_cnt[k] <= starve_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Output stage: unused ports keep their last address/data and only drop the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_o    <= '0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else begin
            we_o <= port_we;
            for (int p = 0; p < NUM_WP; p++) begin
                if (port_we[p]) begin
                    waddr_o[p*ADDR_WIDTH +: ADDR_WIDTH] <= port_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_o[p*DATA_WIDTH +: DATA_WIDTH] <= port_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef RF_WB_FWD_EN
    // Forward the pending regfile write; same-cycle duplicates never coexist, so at most one port matches.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int p = 0; p < NUM_WP; p++) begin
            if (!fwd_hit_o && we_o[p] && (fwd_raddr_i != '0) &&
                (waddr_o[p*ADDR_WIDTH +: ADDR_WIDTH] == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = wdata_o[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_port_arbiter.sv
// Purpose: self-checking bench for rf_wb_port_arbiter (vector table + scoreboard of expected regfile writes).
// Latency: ready checked in the grant cycle, writes checked one cycle later from the queue.
// Backpressure: stalled requesters keep their addr/data; data is derived from (requester, addr).
module tb_rf_wb_port_arbiter;

    localparam int NR = 4;
    localparam int NW = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              arb_en;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NR-1:0]     starved;
`ifdef RF_WB_FWD_EN
    logic [AW-1:0]     fwd_raddr;
    logic              fwd_hit;
    logic [DW-1:0]     fwd_data;
`endif

    always #5 clk = ~clk;

    rf_wb_port_arbiter #(
        .NUM_REQ(NR), .NUM_WP(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arb_en_i(arb_en),
        .req_valid_i(req_valid),
        .req_addr_i(req_addr),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .we_o(we),
        .waddr_o(waddr),
        .wdata_o(wdata),
        .starved_o(starved)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_raddr_i(fwd_raddr),
        .fwd_hit_o(fwd_hit),
        .fwd_data_o(fwd_data)
`endif
    );

    typedef struct {
        logic       en;
        logic [3:0] vld;
        logic [4:0] a0, a1, a2, a3;
        logic [3:0] rdy;
        logic [3:0] stv;
        logic [1:0] we;
        int         s0, s1;
    } vec_t;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
    } exp_t;

    vec_t        tv [21];
    exp_t        sbq [$];
    logic [4:0]  last_a [NW];
    logic [31:0] last_d [NW];
    int          total = 0;
    int          bad   = 0;

    function automatic vec_t mk(logic en, logic [3:0] vld, logic [4:0] a0, logic [4:0] a1,
                                logic [4:0] a2, logic [4:0] a3, logic [3:0] rdy,
                                logic [3:0] stv, logic [1:0] w, int s0, int s1);
        vec_t v;
        v.en = en; v.vld = vld; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.rdy = rdy; v.stv = stv; v.we = w; v.s0 = s0; v.s1 = s1;
        return v;
    endfunction

    function automatic logic [31:0] data_of(int k, logic [4:0] a);
        return 32'hD000_0000 | (32'(k) << 8) | {27'd0, a};
    endfunction

    function automatic logic [4:0] addr_of(vec_t v, int s);
        case (s)
            0:       return v.a0;
            1:       return v.a1;
            2:       return v.a2;
            default: return v.a3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t v);
        arb_en    = v.en;
        req_valid = v.vld;
        req_addr  = {v.a3, v.a2, v.a1, v.a0};
        req_data  = {data_of(3, v.a3), data_of(2, v.a2), data_of(1, v.a1), data_of(0, v.a0)};
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.we = v.we;
        e.a0 = addr_of(v, v.s0);
        e.d0 = data_of(v.s0, e.a0);
        e.a1 = addr_of(v, v.s1);
        e.d1 = data_of(v.s1, e.a1);
        sbq.push_back(e);
    endtask

    // Pops the write expected from the previous grant cycle; disabled ports must hold.
    task automatic check_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        chk({tag, " we"}, 64'(we), 64'(e.we));
        for (int p = 0; p < NW; p++) begin
            if (e.we[p]) begin
                last_a[p] = (p == 0) ? e.a0 : e.a1;
                last_d[p] = (p == 0) ? e.d0 : e.d1;
            end
            chk($sformatf("%s waddr%0d", tag, p), 64'(waddr[p*AW +: AW]), 64'(last_a[p]));
            chk($sformatf("%s wdata%0d", tag, p), 64'(wdata[p*DW +: DW]), 64'(last_d[p]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rr 0->2->0, four distinct writes in two cycles
        tv[0]  = mk(1, 4'b1111, 1, 2, 3, 4, 4'b0011, 4'b0000, 2'b11, 0, 1);
        tv[1]  = mk(1, 4'b1111, 1, 2, 3, 4, 4'b1100, 4'b0000, 2'b11, 2, 3);
        // same-address duplicate: req0 first, req1 next cycle
        tv[2]  = mk(1, 4'b0011, 7, 7, 0, 0, 4'b0001, 4'b0000, 2'b01, 0, 0);
        tv[3]  = mk(1, 4'b0010, 7, 7, 0, 0, 4'b0010, 4'b0000, 2'b01, 1, 0);
        // x0 takes no port; x0 still granted once ports are full
        tv[4]  = mk(1, 4'b0111, 5, 6, 0, 0, 4'b0111, 4'b0000, 2'b11, 0, 1);
        tv[5]  = mk(1, 4'b1111, 1, 0, 2, 3, 4'b1110, 4'b0000, 2'b11, 2, 3);
        // req1/req2/req3 share x9; ptr parks at 1 so req3 keeps losing
        tv[6]  = mk(1, 4'b1111, 1, 9, 9, 9, 4'b0101, 4'b0000, 2'b11, 2, 0);
        for (int r = 7; r <= 13; r++) begin
            tv[r] = mk(1, 4'b1111, 1, 9, 9, 9, 4'b0011, 4'b0000, 2'b11, 1, 0);
        end
        tv[14] = mk(1, 4'b1111, 1, 9, 9, 9, 4'b1001, 4'b1000, 2'b11, 3, 0);
        tv[15] = mk(1, 4'b1111, 1, 9, 9, 9, 4'b0101, 4'b0100, 2'b11, 2, 0);
        // arbitration off for three cycles, then resume from rr_ptr=1
        for (int r = 16; r <= 18; r++) begin
            tv[r] = mk(0, 4'b1111, 1, 9, 9, 9, 4'b0000, 4'b0000, 2'b00, 0, 0);
        end
        tv[19] = mk(1, 4'b1111, 1, 2, 3, 4, 4'b0110, 4'b0000, 2'b11, 1, 2);
        tv[20] = mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0);

        for (int p = 0; p < NW; p++) begin
            last_a[p] = '0;
            last_d[p] = '0;
        end
`ifdef RF_WB_FWD_EN
        fwd_raddr = '0;
`endif

        // reset state, with live requests to prove ready stays low
        rst = 1'b1;
        apply_row(tv[0]);
        repeat (2) @(negedge clk);
        chk("reset ready", 64'(req_ready), 64'd0);
        chk("reset we", 64'(we), 64'd0);
        chk("reset waddr", 64'(waddr), 64'd0);
        chk("reset wdata", 64'(wdata), 64'd0);
        chk("reset starved", 64'(starved), 64'd0);
        arb_en    = 1'b0;
        req_valid = '0;
        rst       = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 21; r++) begin
            apply_row(tv[r]);
            @(negedge clk);
            chk($sformatf("row%0d ready", r), 64'(req_ready), 64'(tv[r].rdy));
            chk($sformatf("row%0d starved", r), 64'(starved), 64'(tv[r].stv));
            check_out($sformatf("row%0d out", r - 1));
            push_exp(tv[r]);
            @(posedge clk);
            #1;
        end
        arb_en    = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check_out("flush out");

        // reset while a write sits in the output stage
        @(posedge clk);
        #1;
        arb_en         = 1'b1;
        req_valid      = 4'b0001;
        req_addr[4:0]  = 5'd9;
        req_data[31:0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("x9 ready", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        arb_en    = 1'b0;
        req_valid = '0;
        chk("x9 we", 64'(we), 64'h1);
        chk("x9 waddr", 64'(waddr[4:0]), 64'd9);
        chk("x9 wdata", 64'(wdata[31:0]), 64'hDEADBEEF);
`ifdef RF_WB_FWD_EN
        fwd_raddr = 5'd9;
        #1;
        chk("fwd hit x9", 64'(fwd_hit), 64'd1);
        chk("fwd data x9", 64'(fwd_data), 64'hDEADBEEF);
        fwd_raddr = 5'd0;
        #1;
        chk("fwd hit x0", 64'(fwd_hit), 64'd0);
        chk("fwd data x0", 64'(fwd_data), 64'd0);
        fwd_raddr = 5'd9;
`endif
        #1;
        arb_en    = 1'b1;
        req_valid = 4'b0001;
        rst       = 1'b1;
        #1;
        chk("midrst we", 64'(we), 64'd0);
        chk("midrst waddr", 64'(waddr), 64'd0);
        chk("midrst ready", 64'(req_ready), 64'd0);
`ifdef RF_WB_FWD_EN
        chk("midrst fwd hit", 64'(fwd_hit), 64'd0);
`endif
        arb_en    = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
